// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 16x-oversampling 8N1 receiver for the ultrasonic sensor's serial line.
// Good bytes are presented with a one-cycle strobe; bad frames raise a separate
// strobe and never reach byte_data. The stop bit is decided mid-bit so that
// back-to-back frames with no idle time are still received.
module uart_rx_8n1 #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter bit RX_INVERT = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       framing_err
);

    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // A divider below 2 cannot produce distinct ticks, so refuse to build.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_rx_8n1: CLK_HZ / (BAUD*16) must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             sync_1;
    logic             sync_2;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       sample_cnt;
    logic [2:0]       bit_cnt;
    logic             samp_7;
    logic             samp_8;
    logic             vote;
    logic [7:0]       shift_reg;
    logic             start_det;
    logic             load_byte;
    logic             set_err;

    // Two-flop synchroniser for the asynchronous line; idles high out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= rx;
            sync_2 <= sync_1;
        end
    end

    assign rx_s = sync_2 ^ RX_INVERT;

    // The divider only runs inside a frame, so ticks are phase-locked to the start edge.
    assign tick = (state == START || state == DATA || state == STOP) && (div_cnt == DIV_LAST);

    // Majority of the three mid-bit samples; the third sample is the live one on tick 9.
    assign vote = (samp_7 & samp_8) | (samp_7 & rx_s) | (samp_8 & rx_s);

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the single-cycle control decisions of the frame.
    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        load_byte  = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    start_det  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (sample_cnt == 4'd9 && vote) begin
                        state_next = IDLE;
                    end else if (sample_cnt == 4'd15) begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (tick && sample_cnt == 4'd15 && bit_cnt == 3'd7) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick && sample_cnt == 4'd9) begin
                    if (vote) begin
                        load_byte  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        set_err    = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Baud-tick divider, parked at zero while waiting for a start edge or a break to end.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (state == IDLE || state == BREAK || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Sample and bit counters, both restarted by the start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt <= 4'd0;
            bit_cnt    <= 3'd0;
        end else if (start_det) begin
            sample_cnt <= 4'd0;
            bit_cnt    <= 3'd0;
        end else if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (state == DATA && sample_cnt == 4'd15) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Capture the tick-7 and tick-8 samples and shift data bits in LSB-first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            samp_7    <= 1'b0;
            samp_8    <= 1'b0;
            shift_reg <= 8'h00;
        end else if (tick) begin
            if (sample_cnt == 4'd7) begin
                samp_7 <= rx_s;
            end
            if (sample_cnt == 4'd8) begin
                samp_8 <= rx_s;
            end
            if (state == DATA && sample_cnt == 4'd9) begin
                shift_reg <= {vote, shift_reg[7:1]};
            end
        end
    end

    // Output register and strobes; byte_data only ever changes alongside byte_ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_data   <= 8'h00;
            byte_ready  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            byte_ready  <= load_byte;
            framing_err <= set_err;
            if (load_byte) begin
                byte_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed testbench for uart_rx_8n1 at DIV = 10 (160-cycle bit period).
// A monitor logs every strobe with its cycle number; scenario tasks drive the
// serial line and compare the log against hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_rx_8n1;

    localparam int BIT_NS = 1600;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       framing_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int both_cnt = 0;

    int         rdy_cyc_q[$];
    logic [7:0] rdy_data_q[$];
    int         err_cyc_q[$];
    int         start_q[$];

    uart_rx_8n1 #(
        .CLK_HZ(1_600_000),
        .BAUD(10_000),
        .RX_INVERT(1'b0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx(rx),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .framing_err(framing_err)
    );

    // 10 ns clock; rising edges at odd multiples of 5 ns, so line changes on
    // even nanoseconds never coincide with an active edge.
    always #5 clock = ~clock;

    // Rising-edge counter used to time-stamp strobes.
    always @(posedge clock) cyc <= cyc + 1;

    // Strobe monitor, sampling on the falling edge.
    always @(negedge clock) begin
        if (byte_ready) begin
            rdy_cyc_q.push_back(cyc);
            rdy_data_q.push_back(byte_data);
        end
        if (framing_err) err_cyc_q.push_back(cyc);
        if (byte_ready && framing_err) both_cnt++;
    end

    task automatic clear_log();
        rdy_cyc_q.delete();
        rdy_data_q.delete();
        err_cyc_q.delete();
        start_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_val);
        start_q.push_back(cyc + 1);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_val;
        #(bit_ns);
    endtask

    task automatic wait_strobes(input int n);
        for (int i = 0; i < 400 && (rdy_cyc_q.size() + err_cyc_q.size()) < n; i++) begin
            @(negedge clock);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            rx = ~rx;
            total++;
            if ({byte_data, byte_ready, framing_err} !== 10'h000) begin
                bad++;
                $display("[TB] FAIL reset_hold: observed data=%h rdy=%b err=%b expected 00/0/0",
                         byte_data, byte_ready, framing_err);
            end
        end
        rx = 1'b1;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        clear_log();
        repeat (400) @(negedge clock);
        total++;
        if (rdy_cyc_q.size() + err_cyc_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL reset_idle_strobes: observed %0d strobes expected 0",
                     rdy_cyc_q.size() + err_cyc_q.size());
        end
    endtask

    task automatic test_single_byte();
        clear_log();
        send_byte(8'h52, BIT_NS, 1'b1);
        wait_strobes(1);
        total++;
        if (rdy_cyc_q.size() !== 1) begin
            bad++;
            $display("[TB] FAIL single_count: observed %0d pulses expected 1", rdy_cyc_q.size());
        end
        if (rdy_cyc_q.size() > 0) begin
            total++;
            if (rdy_data_q[0] !== 8'h52) begin
                bad++;
                $display("[TB] FAIL single_data: observed %h expected 52", rdy_data_q[0]);
            end
            total++;
            if (rdy_cyc_q[0] - start_q[0] < 1541 || rdy_cyc_q[0] - start_q[0] > 1543) begin
                bad++;
                $display("[TB] FAIL single_latency: observed %0d expected 1542+-1",
                         rdy_cyc_q[0] - start_q[0]);
            end
        end
        total++;
        if (err_cyc_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL single_err: observed %0d framing errors expected 0", err_cyc_q.size());
        end
    endtask

    task automatic test_back_to_back(input int bit_ns, input bit check_spacing);
        logic [7:0] msg [5];
        msg = '{8'h52, 8'h31, 8'h32, 8'h33, 8'h0D};
        clear_log();
        for (int i = 0; i < 5; i++) send_byte(msg[i], bit_ns, 1'b1);
        wait_strobes(5);
        total++;
        if (rdy_cyc_q.size() !== 5) begin
            bad++;
            $display("[TB] FAIL b2b_count(bit=%0dns): observed %0d pulses expected 5",
                     bit_ns, rdy_cyc_q.size());
        end
        for (int i = 0; i < 5 && i < rdy_cyc_q.size(); i++) begin
            total++;
            if (rdy_data_q[i] !== msg[i]) begin
                bad++;
                $display("[TB] FAIL b2b_data[%0d](bit=%0dns): observed %h expected %h",
                         i, bit_ns, rdy_data_q[i], msg[i]);
            end
            if (check_spacing && i > 0) begin
                total++;
                if (rdy_cyc_q[i] - rdy_cyc_q[i-1] < 1598 || rdy_cyc_q[i] - rdy_cyc_q[i-1] > 1602) begin
                    bad++;
                    $display("[TB] FAIL b2b_spacing[%0d]: observed %0d expected 1600+-2",
                             i, rdy_cyc_q[i] - rdy_cyc_q[i-1]);
                end
            end
        end
        total++;
        if (err_cyc_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL b2b_err(bit=%0dns): observed %0d framing errors expected 0",
                     bit_ns, err_cyc_q.size());
        end
    endtask

    task automatic test_glitch();
        clear_log();
        rx = 1'b0;
        repeat (40) @(negedge clock);
        rx = 1'b1;
        repeat (480) @(negedge clock);
        total++;
        if (rdy_cyc_q.size() + err_cyc_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL glitch_strobes: observed %0d strobes expected 0",
                     rdy_cyc_q.size() + err_cyc_q.size());
        end
        clear_log();
        send_byte(8'hA5, BIT_NS, 1'b1);
        wait_strobes(1);
        total++;
        if (rdy_cyc_q.size() !== 1 || rdy_data_q[0] !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL glitch_followup: observed %0d pulses data %h expected 1 pulse A5",
                     rdy_cyc_q.size(), byte_data);
        end
    endtask

    task automatic test_framing_break();
        clear_log();
        send_byte(8'h55, BIT_NS, 1'b1);
        wait_strobes(1);
        total++;
        if (byte_data !== 8'h55) begin
            bad++;
            $display("[TB] FAIL frame_pre_byte: observed %h expected 55", byte_data);
        end
        clear_log();
        send_byte(8'hC3, BIT_NS, 1'b0);
        #(5 * BIT_NS);
        rx = 1'b1;
        #(2 * BIT_NS);
        total++;
        if (err_cyc_q.size() !== 1) begin
            bad++;
            $display("[TB] FAIL frame_err_count: observed %0d expected 1", err_cyc_q.size());
        end
        if (err_cyc_q.size() > 0) begin
            total++;
            if (err_cyc_q[0] - start_q[0] < 1541 || err_cyc_q[0] - start_q[0] > 1543) begin
                bad++;
                $display("[TB] FAIL frame_err_latency: observed %0d expected 1542+-1",
                         err_cyc_q[0] - start_q[0]);
            end
        end
        total++;
        if (rdy_cyc_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL frame_no_ready: observed %0d pulses expected 0", rdy_cyc_q.size());
        end
        total++;
        if (byte_data !== 8'h55) begin
            bad++;
            $display("[TB] FAIL frame_data_hold: observed %h expected 55", byte_data);
        end
        clear_log();
        send_byte(8'h0D, BIT_NS, 1'b1);
        wait_strobes(1);
        total++;
        if (rdy_cyc_q.size() !== 1 || rdy_data_q[0] !== 8'h0D || err_cyc_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL frame_recover: observed %0d pulses %0d errs data %h expected 1/0/0D",
                     rdy_cyc_q.size(), err_cyc_q.size(), byte_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h33;
        clear_log();
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = b[4];
        #(BIT_NS / 2);
        reset_n = 1'b0;
        #1;
        total++;
        if ({byte_data, byte_ready, framing_err} !== 10'h000) begin
            bad++;
            $display("[TB] FAIL midreset_async: observed data=%h rdy=%b err=%b expected 00/0/0",
                     byte_data, byte_ready, framing_err);
        end
        rx = 1'b1;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        #(2 * BIT_NS);
        total++;
        if (rdy_cyc_q.size() + err_cyc_q.size() !== 0 || byte_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL midreset_quiet: observed %0d strobes data %h expected 0 strobes 00",
                     rdy_cyc_q.size() + err_cyc_q.size(), byte_data);
        end
        clear_log();
        send_byte(8'h33, BIT_NS, 1'b1);
        wait_strobes(1);
        total++;
        if (rdy_cyc_q.size() !== 1 || rdy_data_q[0] !== 8'h33) begin
            bad++;
            $display("[TB] FAIL midreset_next: observed %0d pulses data %h expected 1 pulse 33",
                     rdy_cyc_q.size(), byte_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        #(BIT_NS);
        test_back_to_back(BIT_NS, 1'b1);
        #(BIT_NS);
        test_glitch();
        #(BIT_NS);
        test_framing_break();
        #(BIT_NS);
        test_reset_mid_frame();
        #(BIT_NS);
        test_back_to_back(1632, 1'b0);
        #(BIT_NS);
        test_back_to_back(1568, 1'b0);
        total++;
        if (both_cnt !== 0) begin
            bad++;
            $display("[TB] FAIL strobe_overlap: observed %0d overlapping cycles expected 0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
